// File: rtl/wb_pkg.sv
// Shared widths and packed-slice helpers for the writeback arbiter.
// WB_RR_ARB_EN selects round-robin arbitration; default is fixed priority.
package wb_pkg;

    localparam int INT32W       = 32;
    localparam int REGFILE_SIZE = 5;
    localparam int NUM_REQ      = 3;

    function automatic logic [REGFILE_SIZE-1:0] rd_slice(
        input logic [NUM_REQ*REGFILE_SIZE-1:0] v,
        input int unsigned                     i
    );
        return REGFILE_SIZE'(v >> (i * REGFILE_SIZE));
    endfunction

    function automatic logic [INT32W-1:0] data_slice(
        input logic [NUM_REQ*INT32W-1:0] v,
        input int unsigned               i
    );
        return INT32W'(v >> (i * INT32W));
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: requesters drive valid/rd/data,
// the arbiter answers with a one-hot ready.
interface regfile_wb_arbiter_if #(
    parameter int INT32W       = wb_pkg::INT32W,
    parameter int REGFILE_SIZE = wb_pkg::REGFILE_SIZE,
    parameter int NUM_REQ      = wb_pkg::NUM_REQ
) ();

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*REGFILE_SIZE-1:0] req_rd;
    logic [NUM_REQ*INT32W-1:0]       req_data;
    logic [NUM_REQ-1:0]              req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Request vector to one-hot grant. WB_RR_ARB_EN: round-robin with a
// last-grant pointer; otherwise fixed priority, lowest index wins.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int N = NUM_REQ
) (
`ifdef WB_RR_ARB_EN
    input  logic         clk,
    input  logic         reset,
`endif
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

`ifdef WB_RR_ARB_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    int            t;

    // Search starts one above the last grant and wraps at N-1.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = '0;
        t       = 0;
        for (int k = 1; k <= N; k++) begin
            t = int'(ptr) + k;
            if (t >= N) t = t - N;
            idx = PW'(t);
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
                ptr_nxt    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= ptr_nxt;
        end
    end
`else
    assign grant = req & (~req + N'(1));
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among writeback sources, tracks a busy
// scoreboard and flags RAW hazards. WB_RR_ARB_EN enables round-robin.
module regfile_wb_arbiter #(
    parameter int INT32W       = wb_pkg::INT32W,
    parameter int REGFILE_SIZE = wb_pkg::REGFILE_SIZE,
    parameter int NUM_REQ      = wb_pkg::NUM_REQ
) (
    input  logic                         clk,
    input  logic                         reset,
    regfile_wb_arbiter_if.slave          bus,
    input  logic                         issue_valid,
    input  logic [REGFILE_SIZE-1:0]      issue_rd,
    input  logic [REGFILE_SIZE-1:0]      chk_rs1,
    input  logic [REGFILE_SIZE-1:0]      chk_rs2,
    output logic                         hazard_rs1,
    output logic                         hazard_rs2,
    output logic [2**REGFILE_SIZE-1:0]   busy,
    output logic [REGFILE_SIZE-1:0]      rf_rd,
    output logic [INT32W-1:0]            rf_dataRd
);

    localparam int NREG = 2 ** REGFILE_SIZE;

    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      ready;
    logic                    xfer;
    logic [REGFILE_SIZE-1:0] sel_rd;
    logic [INT32W-1:0]       sel_data;
    logic [NREG-1:0]         busy_nxt;

    wb_rr_arbiter #(
        .N     (NUM_REQ)
    ) u_arb (
`ifdef WB_RR_ARB_EN
        .clk   (clk),
        .reset (reset),
`endif
        .req   (bus.req_valid),
        .grant (grant)
    );

    assign ready         = grant & {NUM_REQ{reset}};
    assign bus.req_ready = ready;
    assign xfer          = |(bus.req_valid & ready);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                sel_rd   = wb_pkg::rd_slice(bus.req_rd, i);
                sel_data = wb_pkg::data_slice(bus.req_data, i);
            end
        end
    end

    // A same-cycle issue to the written register must stay busy.
    always_comb begin
        busy_nxt = busy;
        if (xfer) busy_nxt[sel_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_rd     <= '0;
            rf_dataRd <= '0;
            busy      <= '0;
        end else begin
            rf_rd     <= xfer ? sel_rd : '0;
            rf_dataRd <= xfer ? sel_data : '0;
            busy      <= busy_nxt;
        end
    end

    // rf_rd term covers the write still one edge from commit.
    assign hazard_rs1 = (chk_rs1 != '0) &&
                        (busy[chk_rs1] || rf_rd == chk_rs1);
    assign hazard_rs2 = (chk_rs2 != '0) &&
                        (busy[chk_rs2] || rf_rd == chk_rs2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small regfile model
// on the write port for read-back.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic [31:0] busy;
    logic [4:0]  rf_rd;
    logic [31:0] rf_dataRd;
    logic [31:0] rf_model [32];

    int passed;
    int total;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard_rs1  (hazard_rs1),
        .hazard_rs2  (hazard_rs2),
        .busy        (busy),
        .rf_rd       (rf_rd),
        .rf_dataRd   (rf_dataRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile write port: no enable, rd=0 is the idle write.
    always @(posedge clk) begin
        if (rf_rd != 5'd0) rf_model[rf_rd] <= rf_dataRd;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [4:0] rd,
                           input logic [31:0] data);
        bus.req_rd[i*5 +: 5]    = rd;
        bus.req_data[i*32 +: 32] = data;
    endtask

    logic [2:0] exp_gnt [6];
    logic [4:0] exp_rd;

    initial begin
        passed = 0;
        total  = 0;
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
`ifdef WB_RR_ARB_EN
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        reset         = 1'b0;
        issue_valid   = 1'b0;
        issue_rd      = '0;
        chk_rs1       = '0;
        chk_rs2       = '0;
        bus.req_valid = 3'b111;
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);

        // 1. reset with active requests
        repeat (2) @(negedge clk);
        chk("rst_rf_rd", 64'(rf_rd), 64'd0);
        chk("rst_data", 64'(rf_dataRd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);

        // 2. single write and read-back
        reset         = 1'b1;
        bus.req_valid = 3'b001;
        set_req(0, 5'd5, 32'hDEADBEEF);
        #1;
        chk("w1_ready", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        bus.req_valid = 3'b000;
        chk("w1_rf_rd", 64'(rf_rd), 64'd5);
        chk("w1_data", 64'(rf_dataRd), 64'hDEADBEEF);
        chk("w1_precommit", 64'(rf_model[5]), 64'd0);
        @(negedge clk);
        chk("w1_readback", 64'(rf_model[5]), 64'hDEADBEEF);
        chk("w1_idle_rd", 64'(rf_rd), 64'd0);

        // requester 2 alone, leaves the RR pointer at 2
        bus.req_valid = 3'b100;
        set_req(2, 5'd3, 32'h33);
        #1;
        chk("r2_ready", 64'(bus.req_ready), 64'b100);
        @(negedge clk);
        bus.req_valid = 3'b000;
        chk("r2_rf_rd", 64'(rf_rd), 64'd3);

        // 3. contention for 6 transfers
        set_req(0, 5'd10, 32'hA0);
        set_req(1, 5'd11, 32'hA1);
        set_req(2, 5'd12, 32'hA2);
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("ct_gnt%0d", k), 64'(bus.req_ready),
                64'(exp_gnt[k]));
            exp_rd = exp_gnt[k] == 3'b001 ? 5'd10 :
                     exp_gnt[k] == 3'b010 ? 5'd11 : 5'd12;
            @(negedge clk);
            chk($sformatf("ct_rd%0d", k), 64'(rf_rd), 64'(exp_rd));
        end
        bus.req_valid = 3'b000;
        chk("ct_busy", 64'(busy), 64'd0);

        // 4. scoreboard and hazard on x7
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        chk_rs1     = 5'd7;
        chk_rs2     = 5'd8;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("sb_busy7", 64'(busy), 64'h80);
        chk("sb_haz1", 64'(hazard_rs1), 64'd1);
        chk("sb_haz2", 64'(hazard_rs2), 64'd0);
        bus.req_valid = 3'b010;
        set_req(1, 5'd7, 32'h77);
        #1;
        chk("sb_ready", 64'(bus.req_ready), 64'b010);
        @(negedge clk);
        bus.req_valid = 3'b000;
        chk("sb_clr7", 64'(busy), 64'd0);
        chk("sb_inflight", 64'(rf_rd), 64'd7);
        chk("sb_haz_fly", 64'(hazard_rs1), 64'd1);
        @(negedge clk);
        chk("sb_haz_drop", 64'(hazard_rs1), 64'd0);
        chk("sb_commit7", 64'(rf_model[7]), 64'h77);

        // 5. issue and transfer to x9 on the same edge
        issue_valid   = 1'b1;
        issue_rd      = 5'd9;
        chk_rs2       = 5'd9;
        bus.req_valid = 3'b001;
        set_req(0, 5'd9, 32'h99);
        @(negedge clk);
        issue_valid   = 1'b0;
        bus.req_valid = 3'b000;
        chk("x9_busy", 64'(busy), 64'h200);
        chk("x9_rf_rd", 64'(rf_rd), 64'd9);
        chk("x9_haz2", 64'(hazard_rs2), 64'd1);

        // 6. zero register
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        chk_rs1     = 5'd0;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("z_issue", 64'(busy), 64'h200);
        chk("z_haz1", 64'(hazard_rs1), 64'd0);
        bus.req_valid = 3'b001;
        set_req(0, 5'd0, 32'h1234);
        #1;
        chk("z_ready", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        bus.req_valid = 3'b000;
        chk("z_rf_rd", 64'(rf_rd), 64'd0);
        chk("z_data", 64'(rf_dataRd), 64'h1234);
        @(negedge clk);
        chk("z_model0", 64'(rf_model[0]), 64'd0);
        chk("z_busy", 64'(busy), 64'h200);

        // reset mid-operation drops the in-flight write
        issue_valid   = 1'b1;
        issue_rd      = 5'd6;
        bus.req_valid = 3'b001;
        set_req(0, 5'd4, 32'h44);
        @(posedge clk);
        #2;
        issue_valid   = 1'b0;
        bus.req_valid = 3'b000;
        chk("mid_pre_rd", 64'(rf_rd), 64'd4);
        chk("mid_pre_busy", 64'(busy), 64'h240);
        reset = 1'b0;
        #1;
        chk("mid_rf_rd", 64'(rf_rd), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        bus.req_valid = 3'b011;
        #1;
        chk("mid_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("mid_model4", 64'(rf_model[4]), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
